// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART TX, 8N1 LSB first (even parity bit added when UART_TX_PARITY_EN is defined); in clk, reset, tx_data[7:0], tx_valid; out tx_busy (comb, includes strobe cycle), tx_done, tx_overrun (sticky), txd (registered, idle high)
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun,
  output logic       txd
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par, par_n;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic txd_n, done_n, ovr_n, tc;
  assign tx_busy = (state != IDLE) | tx_valid;
  assign tc = cnt == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      txd <= 1'b1;
      tx_done <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      txd <= txd_n;
      tx_done <= done_n;
      tx_overrun <= ovr_n;
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) par <= reset ? 1'b0 : par_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || tc) ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    txd_n = txd;
    done_n = 1'b0;
    ovr_n = tx_overrun | (tx_valid & (state != IDLE));
`ifdef UART_TX_PARITY_EN
    par_n = par;
`endif
    case (state)
      IDLE: if (tx_valid) begin
        state_n = START;
        shift_n = tx_data;
        idx_n = '0;
        txd_n = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n = ^tx_data;
`endif
      end
      START: if (tc) begin
        state_n = DATA;
        txd_n = shift[0];
      end
      DATA: if (tc) begin
        shift_n = shift >> 1;
        idx_n = idx + 3'd1;
        txd_n = shift[1];
        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          txd_n = par;
`else
          state_n = STOP;
          txd_n = 1'b1;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tc) begin
        state_n = STOP;
        txd_n = 1'b1;
      end
`endif
      STOP: if (tc) begin
        state_n = IDLE;
        txd_n = 1'b1;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
